sr_flag_arbiter: RTL
====================

# sr_flag_arbiter

Round-robin arbiter that shares one bank of set/reset status flags between several requesters. Each requester issues set/reset commands against a flag index; one command is granted per cycle and applied to the bank with SR semantics. The forbidden S=R=1 combination is rejected and counted. The block sits between the control agents and the status-flag bank they share.

## Interface
- NREQ, 4: number of requesters (2..8).
- NFLAG, 8: number of flags in the bank.
- IDXW, 3: flag index width; NFLAG ≤ 2^IDXW.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- clear_all  in  1  synchronous clear of all flags.
- req_valid  in  NREQ  command valid, one bit per requester.
- req_sr  in  2*NREQ  {s,r} per requester; requester i uses bits [2i+1:2i], s is the upper bit.
- req_idx  in  IDXW*NREQ  target flag index per requester; requester i uses bits [IDXW*i+IDXW-1:IDXW*i].
- req_ready  out  NREQ  one-hot grant (combinational) for the current cycle.
- flags  out  NFLAG  flag bank state (registered).
- err_pulse  out  1  one-cycle pulse when a granted command is illegal.
- err_count  out  8  saturating count of illegal commands.

## Operation
- Reset (reset=0, asynchronous): flags=0, err_pulse=0, err_count=0, rr_ptr=0. req_ready=0 while reset is asserted.
- Arbitration:
  - rr_ptr selects the highest-priority requester.
  - Search order is rr_ptr, rr_ptr+1, …, wrapping modulo NREQ.
  - The first requester with req_valid=1 is granted.
  - At most one req_ready bit is high. A command transfers when req_valid & req_ready.
- Pointer update: after a transfer from requester g, rr_ptr = (g+1) mod NREQ. rr_ptr is unchanged when nothing transfers.
- Command decode, applied to flags[idx] at the next clock edge:
  - 00: hold. The grant is still consumed and the pointer still advances.
  - 01: clear flag to 0.
  - 10: set flag to 1.
  - 11: illegal. Flag unchanged, err_pulse=1 next cycle, err_count += 1, saturating at 255.
- idx ≥ NFLAG is treated as illegal: same handling as 11.
- clear_all=1:
  - All flags go to 0 at the next edge.
  - req_ready is forced to 0 and no grant occurs that cycle.
  - rr_ptr and err_count are unchanged.
- Only the indexed flag changes. All other flags hold.

## Timing
- The grant is combinational from req_valid, rr_ptr and clear_all in the same cycle.
- Flag update latency is 1 cycle: a command transferred at edge t is visible on flags after edge t.
- err_pulse rises in the cycle after the illegal transfer and lasts exactly 1 cycle.
- err_count updates on the same edge as err_pulse.
- Back-to-back transfers to the same flag are allowed. Each cycle's command is applied in order.
- Requester handshake:
  - A requester holds req_valid, req_sr and req_idx stable until it sees req_ready.
  - req_valid may drop without a grant. The arbiter keeps no memory of ungranted requests.
- Reset asserted mid-operation:
  - Pending requests are discarded and all state clears immediately.
  - On release, arbitration resumes at requester 0 on the first edge.
- err_count at 255 with a further illegal command: stays 255, and err_pulse still fires.

## Test plan
1. Reset release with no requests: flags=0x00, req_ready=0, err_count=0, err_pulse=0 for 10 cycles.
2. Req0 sends 10 to idx 3, then 01 to idx 3:
   - flags=0x08 one cycle after the first grant.
   - flags=0x00 one cycle after the second grant.
3. All 4 requesters valid continuously, each issuing 10 to its own idx (0..3):
   - grants in order 0,1,2,3,0.
   - flags=0x0F after 4 transfers.
4. Req2 sends 11 to idx 1 while flags=0x02:
   - flags stays 0x02.
   - err_pulse is high for one cycle.
   - err_count=1.
   - rr_ptr advances to 3.
5. flags=0xFF and req1 valid with 01 to idx 0, clear_all=1:
   - req_ready=0 that cycle and flags=0x00 next cycle.
   - On the following cycle req1 is granted and flags stays 0x00.
6. 256 illegal commands (idx=7 with NFLAG=6, or op 11):
   - err_count reaches 255 and stays there.
   - err_pulse fires on every illegal transfer.
   - reset=0 mid-stream clears err_count to 0 asynchronously.

Source files
------------

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter granting one set/reset command per cycle onto a shared
// flag bank; S=R=1 or out-of-range indices are rejected and counted.
module sr_flag_arbiter #(
   parameter int NREQ  = 4,
   parameter int NFLAG = 8,
   parameter int IDXW  = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear_all,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [2*NREQ-1:0]    req_sr,
   input  logic [IDXW*NREQ-1:0] req_idx,
   output logic [NREQ-1:0]      req_ready,
   output logic [NFLAG-1:0]     flags,
   output logic                 err_pulse,
   output logic [7:0]           err_count
);

   localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PTRW-1:0]  r_rr_ptr;
   logic [NFLAG-1:0] r_flags;
   logic             r_err_pulse;
   logic [7:0]       r_err_count;

   logic             w_gnt_any;
   logic [PTRW-1:0]  w_gnt_id;
   logic [1:0]       w_sel_sr;
   logic [IDXW-1:0]  w_sel_idx;
   logic             w_xfer;
   logic             w_illegal;
   logic [PTRW-1:0]  w_ptr_next;

   // Scan from the pointer, wrapping; no grant during clear_all or reset.
   always_comb begin
      int              cand;
      logic [PTRW-1:0] cand_p;
      cand      = 0;
      cand_p    = '0;
      w_gnt_any = 1'b0;
      w_gnt_id  = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = int'(r_rr_ptr) + k;
         if (cand >= NREQ) cand = cand - NREQ;
         cand_p = PTRW'(cand);
         if (!w_gnt_any && req_valid[cand_p]) begin
            w_gnt_any = 1'b1;
            w_gnt_id  = cand_p;
         end
      end
      if (clear_all || !reset) w_gnt_any = 1'b0;
   end

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
         assign req_ready[gi] = w_gnt_any && (w_gnt_id == PTRW'(gi));
      end
   endgenerate

   always_comb begin
      w_sel_sr  = '0;
      w_sel_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (w_gnt_id == PTRW'(k)) begin
            w_sel_sr  = req_sr[2*k +: 2];
            w_sel_idx = req_idx[IDXW*k +: IDXW];
         end
      end
   end

   assign w_xfer     = |(req_valid & req_ready);
   assign w_illegal  = (w_sel_sr == 2'b11) || (int'(w_sel_idx) >= NFLAG);
   assign w_ptr_next = (int'(w_gnt_id) == NREQ - 1) ? '0 : w_gnt_id + 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rr_ptr    <= '0;
         r_flags     <= '0;
         r_err_pulse <= 1'b0;
         r_err_count <= '0;
      end else begin
         r_err_pulse <= 1'b0;
         if (clear_all) begin
            r_flags <= '0;
         end else if (w_xfer) begin
            r_rr_ptr <= w_ptr_next;
            if (w_illegal) begin
               r_err_pulse <= 1'b1;
               if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            end else begin
               // Op 00 is a no-op that still consumes the grant.
               for (int f = 0; f < NFLAG; f++) begin
                  if (w_sel_idx == IDXW'(f)) begin
                     if (w_sel_sr == 2'b10) r_flags[f] <= 1'b1;
                     else if (w_sel_sr == 2'b01) r_flags[f] <= 1'b0;
                  end
               end
            end
         end
      end
   end

   assign flags     = r_flags;
   assign err_pulse = r_err_pulse;
   assign err_count = r_err_count;

endmodule
